// File: rtl/tdm_demux8.sv
// Receive-side TDM demultiplexer: locks to frame_sync, steers each serial bit into
// its channel slot and presents each completed frame in parallel with a valid strobe.
module tdm_demux8 #(
  parameter int N_CH       = 8,
  parameter int MISS_LIMIT = 2,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             din,
  input  logic             frame_sync,
  output logic [N_CH-1:0]  f,
  output logic             frame_valid,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             sync_err
);

  // state  | meaning
  // HUNT   | no frame alignment; waiting for frame_sync
  // LOCKED | aligned; sel tracks the slot of the next sample
  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [2:0]       MISS_MAX = 3'(MISS_LIMIT - 1);

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic [N_CH-1:0]   staging;
  logic [N_CH-1:0]   frame_q;
  logic [2:0]        miss_q;
  logic              valid_q;
  logic              err_q;
  logic [N_CH-1:0]   assembled;

  // Staging bits with the current sample dropped into its slot; at the last slot this
  // is the finished frame.
  always_comb begin
    assembled        = staging;
    assembled[sel_q] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      sel_q   <= '0;
      staging <= '0;
      frame_q <= '0;
      miss_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (EN) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              staging[0] <= din;
              sel_q      <= SEL_ONE;
              miss_q     <= '0;
              state      <= LOCKED;
            end
          end
          LOCKED: begin
            if (sel_q == '0) begin
              if (frame_sync) begin
                staging[0] <= din;
                sel_q      <= SEL_ONE;
                miss_q     <= '0;
              end else if (miss_q >= MISS_MAX) begin
                // Too many absent markers: give up on this alignment.
                err_q  <= 1'b1;
                sel_q  <= '0;
                miss_q <= '0;
                state  <= HUNT;
              end else begin
                staging[0] <= din;
                sel_q      <= SEL_ONE;
                miss_q     <= miss_q + 3'd1;
              end
            end else if (frame_sync) begin
              // Marker in the middle of a frame: restart the frame on this sample.
              err_q      <= 1'b1;
              staging[0] <= din;
              sel_q      <= SEL_ONE;
            end else begin
              staging[sel_q] <= din;
              if (sel_q == SEL_LAST) begin
                frame_q <= assembled;
                valid_q <= 1'b1;
                sel_q   <= '0;
              end else begin
                sel_q <= sel_q + SEL_ONE;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign f           = frame_q & {N_CH{EN}};
  assign frame_valid = valid_q & EN;
  assign sync_err    = err_q & EN;
  assign locked      = (state == LOCKED);
  assign sel         = sel_q;

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the team's 8:1 selector: recovers eight 1-bit channels from a time-division serial stream in which a transmitter scans sel 0..7, one channel per clock.
- Locks to a frame_sync marker, places each received bit into its channel slot and presents the completed 8-bit frame in parallel with a one-cycle valid strobe.
- Sits between the serial link input and the per-channel consumers.

Parameters:
- N_CH, 8, channels per frame; power of two, 2..16.
- SEL_W, $clog2(N_CH), slot counter width; derived, not overridden.
- MISS_LIMIT, 2, consecutive missing syncs at the expected frame start before lock is dropped; legal range 1..7.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- EN  input  1  enable; 0 freezes all state and forces f to 0.
- din  input  1  serial data, one channel bit per enabled clock.
- frame_sync  input  1  high coincident with the channel-0 bit of a frame.
- f  output  N_CH  last complete frame; bit i = channel i; gated with EN.
- frame_valid  output  1  one-cycle pulse when f is updated.
- sel  output  SEL_W  slot index the next enabled sample is assigned to.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on sync at an unexpected slot, or on loss of lock.

Behaviour:
- Reset (asynchronous, while rst=1) sets:
  - state=HUNT, sel=0, staging=0, frame register=0, miss count=0.
  - frame_valid=0, sync_err=0, locked=0, f=0.
- Sampling happens only on rising clk edges with EN=1. With EN=0, every register holds its value, frame_valid and sync_err are 0, and f reads 0. f is the frame register ANDed with {N_CH{EN}}, so the frame register itself is unaffected.
- HUNT state:
  - din is ignored until frame_sync=1.
  - On a sync sample: staging[0]=din, sel=1, miss count=0, go to LOCKED.
- LOCKED state, at each enabled sample:
  - Sync at sel=0: staging[0]=din, sel=1, miss count=0.
  - No sync at sel=0 (flywheel): sample anyway, sel=1, miss count+1. If miss count reaches MISS_LIMIT, pulse sync_err, discard this sample, go to HUNT with sel=0.
  - No sync at sel=k, k>0: staging[k]=din, sel=k+1, wrapping to 0 after N_CH-1.
  - Sync at sel=k, k>0 (misalignment): discard the partial frame, pulse sync_err, treat the sample as channel 0 (staging[0]=din, sel=1), stay LOCKED, no frame_valid.
- Frame completion: when slot N_CH-1 is sampled in LOCKED, the frame register takes the staging bits 0..N_CH-2 with din as the MSB. frame_valid is 1 in the following cycle; latency is one clock after the last bit's sampling edge.
  - Flywheel frames (sync missing but still under MISS_LIMIT) complete normally.
  - f holds its value until the next completion or reset.
- Simultaneous events: sync together with the sel=N_CH-1 sample counts as misalignment (partial frame dropped). rst overrides everything.
- EN deasserted mid-frame: the frame resumes at the frozen sel when EN returns. This does not count as a miss.
- rst asserted mid-frame: the partial frame is lost and f clears to 0 immediately.

Test Plan:
- Reset/hunt: rst=1 then release; drive din=1 with no sync for 20 cycles -> locked=0, frame_valid never pulses, f=8'h00, sel=0.
- Basic frame: sync with channel 0, bits ch0..ch7 = 1,0,1,0,0,1,0,1 -> one cycle after the ch7 edge, f=8'hA5 and frame_valid=1 for exactly one cycle; locked=1.
- Back-to-back frames: 8'hA5 then 8'h3C with syncs -> frame_valid pulses exactly 8 cycles apart; f=8'h3C after the second pulse.
- Misalignment: sync again at sel=3 mid-frame -> sync_err pulses once, partial frame discarded, the next 8 bits give f=8'hFF (when all 1s) with frame_valid 1 clock after the 8th bit.
- Sync loss, MISS_LIMIT=2: lock, then omit syncs -> the first flywheel frame is still delivered. At the second missed frame start, sync_err=1 and locked=0 the next cycle; no further frame_valid until a sync arrives.
- EN and reset: after f=8'hA5, EN=0 -> f=0 and sel frozen; EN=1 -> f=8'hA5 again. Pull EN low for 5 cycles mid-frame -> frame completes correctly after resume. Assert rst mid-frame -> f=0, locked=0 with no clock edge needed.
